pport_arbiter: RTL and testbench
================================

Name: pport_arbiter

Overview:
- Sequences and shares the 8-bit peripheral port (PD bus to the WD33C93A) between two requesters:
  - CPU programmed-I/O accesses, via _CSS.
  - SCSI DMA byte transfers, via _DACK.
- Generates _CSS/_DACK, _IOR/_IOW, the PD drive enable and PDATA_OE_ with parameterised setup/strobe/hold/recovery timing.
- Returns one-cycle acks with read data to the winning requester.
- Sits between the register/DMA front end and the PD_PORT pins.

Parameters:
- SETUP_CLKS, 1, clocks select is asserted before the strobe (1..7)
- STROBE_CLKS, 3, clocks _IOR/_IOW is held low (1..7)
- HOLD_CLKS, 1, clocks select and write data are held after the strobe rises (1..7)
- RECOVER_CLKS, 2, idle clocks after a transfer before the next grant (1..7)

Ports:
- SCLK  in  1  CPU clock (CPUCLKB), all state on rising edge
- RST  in  1  asynchronous active-high reset
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_rw  in  1  1 = read from port, 0 = write
- cpu_wdata  in  8  CPU write byte
- cpu_ack  out  1  one-cycle completion pulse
- dma_req  in  1  DMA transfer request (synchronised DREQ), level
- dma_rw  in  1  1 = read from SCSI (to memory), 0 = write to SCSI
- dma_wdata  in  8  DMA write byte
- dma_ack  out  1  one-cycle completion pulse
- rdata  out  8  captured read byte, shared by both requesters
- pd_out  out  8  byte driven onto PD_PORT
- pd_oe  out  1  1 = drive pd_out onto PD_PORT
- pd_in  in  8  PD_PORT input
- _CSS  out  1  WD33C93A chip select for CPU access, active low
- _DACK  out  1  DMA acknowledge, active low
- _IOR  out  1  read strobe, active low
- _IOW  out  1  write strobe, active low
- PDATA_OE_  out  1  peripheral level-shifter enable, active low
- busy  out  1  1 whenever state is not IDLE

Behaviour:
- Reset (async, RST=1):
  - State = IDLE, counter = 0, last_grant = DMA.
  - _CSS, _DACK, _IOR, _IOW, PDATA_OE_ = 1.
  - pd_oe, cpu_ack, dma_ack, busy = 0; rdata = 8'h00, pd_out = 8'h00.
  - Reset mid-transfer deasserts every strobe/select immediately; no ack is issued; any pending request is re-arbitrated after release.
- All outputs are registered.
- State machine IDLE -> SETUP -> STROBE -> HOLD -> RECOVER -> IDLE.
  - One down-counter is loaded with (X_CLKS-1) on entry to each timed state.
  - A timed state exits on the edge where counter==0.
- IDLE:
  - Arbitration happens only here.
  - If any request is present, latch owner, rw and wdata (into pd_out), then enter SETUP.
- Simultaneous requests:
  - The CPU wins (fixed priority).
  - A request arriving mid-transfer waits; it is never lost.
- SETUP:
  - Owner's select is low: _CSS for CPU, _DACK for DMA.
  - PDATA_OE_ = 0.
  - pd_oe = 1 if write.
- STROBE: adds _IOR=0 (read) or _IOW=0 (write).
  - Read: rdata <= pd_in on the edge leaving STROBE.
- HOLD:
  - Strobe is high.
  - Select, PDATA_OE_ and pd_oe (write) are unchanged.
- Ack:
  - The owner's ack is 1 for exactly the cycle following the edge that leaves HOLD.
  - For reads, rdata is valid in that cycle and holds until the next read capture.
- RECOVER: all selects, strobes, PDATA_OE_ and pd_oe are inactive.
- Latency with defaults and the request high before edge 0:
  - SETUP at e0, STROBE at e1, HOLD at e4, RECOVER at e5.
  - ack during e5-e6; IDLE at e7; next grant at e8.
  - Back-to-back period = SETUP+STROBE+HOLD+RECOVER+1 = 8 clocks.
- Requester protocol:
  - Drop the request on the edge after ack.
  - RECOVER_CLKS>=1 guarantees it is not re-sampled.
  - A request still high in IDLE is a new transfer.
- rw/wdata changes after grant are ignored.
- Never: both _IOR and _IOW low; _CSS and _DACK both low; pd_oe=1 during a read.

Optional Feature:
- PPORT_FAIR_ARB_EN defined:
  - Round-robin on simultaneous requests; the requester not equal to last_grant wins.
  - last_grant updates at each grant.
  - Prevents a streaming DMA from starving CPU register polling, and vice versa.
- Undefined: fixed CPU priority as above; last_grant register is absent.

Decomposition:
- Shared package pport_pkg holds:
  - State encoding localparams: IDLE=3'd0, SETUP=1, STROBE=2, HOLD=3, RECOVER=4.
  - Owner encoding: OWN_CPU=1'b0, OWN_DMA=1'b1.
  - Counter width PPORT_CNT_W=3.
- No sub-module required.
- Optional sub-module pport_timer (loadable 3-bit down-counter with zero flag) if reused by the DMA engine.

Test Plan:
- CPU read, defaults: cpu_req=1, cpu_rw=1, pd_in=8'hAA -> _CSS low e0..e5, _IOR low e1..e4, cpu_ack one cycle after e5, rdata=8'hAA, _DACK stays 1.
- DMA write: dma_req=1, dma_rw=0, dma_wdata=8'h5C -> _DACK low, _IOW low 3 clocks, pd_oe=1 and pd_out=8'h5C SETUP..HOLD, dma_ack single pulse, _IOR stays 1.
- Simultaneous requests held for 3 transfers:
  - Fixed: CPU, CPU, CPU.
  - PPORT_FAIR_ARB_EN: CPU, DMA, CPU.
- Back-to-back DMA reads, pd_in incrementing 8'h01,8'h02 -> grant spacing exactly 8 clocks, rdata 8'h01 then 8'h02, no strobe overlap.
- RST=1 asserted during STROBE of a CPU write -> _IOW/_CSS/PDATA_OE_ go 1 and pd_oe 0 without waiting for a clock edge, no cpu_ack; after release the held cpu_req is re-granted from SETUP.
- Parameter override SETUP=2, STROBE=5, HOLD=2, RECOVER=1 -> strobe width 5 clocks, ack at e9, next grant at e11.

Source files
------------

// File: rtl/pport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pport_pkg
// Description : Shared state, owner and counter definitions for the PD port
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package pport_pkg;

  localparam int PPORT_CNT_W = 3;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DMA = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } pport_state_t;

endpackage : pport_pkg
`default_nettype wire

// File: rtl/pport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pport_arbiter
// Description : Shares the WD33C93A PD port between CPU PIO and SCSI DMA and
//               sequences select/strobe timing. Build option:
//               PPORT_FAIR_ARB_EN selects round-robin arbitration.
// Revision    : 1.0 - initial release
// ============================================================================
module pport_arbiter
  import pport_pkg::*;
#(
  parameter int SETUP_CLKS   = 1,
  parameter int STROBE_CLKS  = 3,
  parameter int HOLD_CLKS    = 1,
  parameter int RECOVER_CLKS = 2
) (
  input  logic       SCLK,
  input  logic       RST,
  input  logic       cpu_req,
  input  logic       cpu_rw,
  input  logic [7:0] cpu_wdata,
  output logic       cpu_ack,
  input  logic       dma_req,
  input  logic       dma_rw,
  input  logic [7:0] dma_wdata,
  output logic       dma_ack,
  output logic [7:0] rdata,
  output logic [7:0] pd_out,
  output logic       pd_oe,
  input  logic [7:0] pd_in,
  output logic       _CSS,
  output logic       _DACK,
  output logic       _IOR,
  output logic       _IOW,
  output logic       PDATA_OE_,
  output logic       busy
);

  localparam logic [PPORT_CNT_W-1:0] c_setup_ld   = PPORT_CNT_W'(SETUP_CLKS - 1);
  localparam logic [PPORT_CNT_W-1:0] c_strobe_ld  = PPORT_CNT_W'(STROBE_CLKS - 1);
  localparam logic [PPORT_CNT_W-1:0] c_hold_ld    = PPORT_CNT_W'(HOLD_CLKS - 1);
  localparam logic [PPORT_CNT_W-1:0] c_recover_ld = PPORT_CNT_W'(RECOVER_CLKS - 1);

  pport_state_t           r_state, w_state_nxt;
  logic [PPORT_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic                   r_owner, w_owner_nxt;
  logic                   r_rw, w_rw_nxt;
  logic                   w_grant;
  logic                   w_grant_owner;
  logic                   w_cnt_zero;
  logic                   w_active;
  logic                   w_leave_hold;
  logic                   w_capture;

`ifdef PPORT_FAIR_ARB_EN
  logic r_last_grant;

  // On a tie the side that did not win last time goes first.
  assign w_grant_owner = (cpu_req && dma_req) ?
                         ((r_last_grant == OWN_DMA) ? OWN_CPU : OWN_DMA) :
                         (cpu_req ? OWN_CPU : OWN_DMA);

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      r_last_grant <= OWN_DMA;
    end else if (w_grant) begin
      r_last_grant <= w_grant_owner;
    end
  end
`else
  assign w_grant_owner = cpu_req ? OWN_CPU : OWN_DMA;
`endif

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_owner <= OWN_DMA;
      r_rw    <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_rw    <= w_rw_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_rw_nxt    = r_rw;
    w_grant     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpu_req || dma_req) begin
          w_grant     = 1'b1;
          w_owner_nxt = w_grant_owner;
          w_rw_nxt    = (w_grant_owner == OWN_CPU) ? cpu_rw : dma_rw;
          w_state_nxt = SETUP;
          w_cnt_nxt   = c_setup_ld;
        end
      end
      SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = STROBE;
          w_cnt_nxt   = c_strobe_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      STROBE: begin
        if (w_cnt_zero) begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = c_hold_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (w_cnt_zero) begin
          w_state_nxt = RECOVER;
          w_cnt_nxt   = c_recover_ld;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      RECOVER: begin
        if (w_cnt_zero) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Pins are decoded from the next state so every output comes straight off a flop.
  assign w_active     = (w_state_nxt == SETUP) || (w_state_nxt == STROBE) ||
                        (w_state_nxt == HOLD);
  assign w_leave_hold = (r_state == HOLD) && w_cnt_zero;
  assign w_capture    = (r_state == STROBE) && w_cnt_zero && r_rw;

  always_ff @(posedge SCLK or posedge RST) begin
    if (RST) begin
      _CSS      <= 1'b1;
      _DACK     <= 1'b1;
      _IOR      <= 1'b1;
      _IOW      <= 1'b1;
      PDATA_OE_ <= 1'b1;
      pd_oe     <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      busy      <= 1'b0;
      rdata     <= 8'h00;
      pd_out    <= 8'h00;
    end else begin
      _CSS      <= !(w_active && (w_owner_nxt == OWN_CPU));
      _DACK     <= !(w_active && (w_owner_nxt == OWN_DMA));
      _IOR      <= !((w_state_nxt == STROBE) && w_rw_nxt);
      _IOW      <= !((w_state_nxt == STROBE) && !w_rw_nxt);
      PDATA_OE_ <= !w_active;
      pd_oe     <= w_active && !w_rw_nxt;
      cpu_ack   <= w_leave_hold && (r_owner == OWN_CPU);
      dma_ack   <= w_leave_hold && (r_owner == OWN_DMA);
      busy      <= (w_state_nxt != IDLE);
      if (w_capture) begin
        rdata <= pd_in;
      end
      if (w_grant) begin
        pd_out <= (w_grant_owner == OWN_CPU) ? cpu_wdata : dma_wdata;
      end
    end
  end

endmodule : pport_arbiter
`default_nettype wire

// File: tb/tb_pport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pport_arbiter
// Description : Directed self-checking bench for pport_arbiter (default and
//               overridden timing instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pport_arbiter;

  logic       SCLK = 1'b0;
  logic       RST  = 1'b1;
  logic       cpu_req = 0, cpu_rw = 0, dma_req = 0, dma_rw = 0;
  logic [7:0] cpu_wdata = 0, dma_wdata = 0, pd_in = 0;
  logic       cpu_ack, dma_ack, pd_oe, css_n, dack_n, ior_n, iow_n, pdoe_n, busy;
  logic [7:0] rdata, pd_out;

  logic       cpu_req2 = 0, cpu_rw2 = 0;
  logic [7:0] cpu_wdata2 = 0;
  logic       cpu_ack2, dma_ack2, pd_oe2, css2_n, dack2_n, ior2_n, iow2_n, pdoe2_n, busy2;
  logic [7:0] rdata2, pd_out2;

  logic [8:0] ctl;
  assign ctl = {css_n, dack_n, ior_n, iow_n, pdoe_n, pd_oe, cpu_ack, dma_ack, busy};

  int vectors = 0;
  int miscompares = 0;

  always #5 SCLK = ~SCLK;

  pport_arbiter u_dut (
    .SCLK(SCLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_rw(cpu_rw), .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_rw(dma_rw), .dma_wdata(dma_wdata), .dma_ack(dma_ack),
    .rdata(rdata), .pd_out(pd_out), .pd_oe(pd_oe), .pd_in(pd_in),
    ._CSS(css_n), ._DACK(dack_n), ._IOR(ior_n), ._IOW(iow_n),
    .PDATA_OE_(pdoe_n), .busy(busy)
  );

  pport_arbiter #(.SETUP_CLKS(2), .STROBE_CLKS(5), .HOLD_CLKS(2), .RECOVER_CLKS(1)) u_dut2 (
    .SCLK(SCLK), .RST(RST),
    .cpu_req(cpu_req2), .cpu_rw(cpu_rw2), .cpu_wdata(cpu_wdata2), .cpu_ack(cpu_ack2),
    .dma_req(1'b0), .dma_rw(1'b0), .dma_wdata(8'h00), .dma_ack(dma_ack2),
    .rdata(rdata2), .pd_out(pd_out2), .pd_oe(pd_oe2), .pd_in(8'h00),
    ._CSS(css2_n), ._DACK(dack2_n), ._IOR(ior2_n), ._IOW(iow2_n),
    .PDATA_OE_(pdoe2_n), .busy(busy2)
  );

  task automatic tick;
    @(posedge SCLK);
    #1;
  endtask

  task automatic wait_idle;
    int k;
    k = 0;
    while (busy && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d clocks, required 0", busy, k);
    end
  endtask

  task automatic test_reset;
    repeat (2) tick();
    vectors++;
    if (ctl !== 9'b1_1_1_1_1_0_0_0_0) begin
      miscompares++;
      $display("FAIL reset_ctl: got %b required %b", ctl, 9'b1_1_1_1_1_0_0_0_0);
    end
    vectors++;
    if (rdata !== 8'h00 || pd_out !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_data: rdata=%h pd_out=%h required 00/00", rdata, pd_out);
    end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_cpu_read;
    logic [8:0] exp_ctl [8];
    exp_ctl = '{9'b0_1_1_1_0_0_0_0_1, 9'b0_1_0_1_0_0_0_0_1, 9'b0_1_0_1_0_0_0_0_1,
                9'b0_1_0_1_0_0_0_0_1, 9'b0_1_1_1_0_0_0_0_1, 9'b1_1_1_1_1_0_1_0_1,
                9'b1_1_1_1_1_0_0_0_1, 9'b1_1_1_1_1_0_0_0_0};
    cpu_req = 1; cpu_rw = 1; pd_in = 8'hAA;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (ctl !== exp_ctl[k]) begin
        miscompares++;
        $display("FAIL cpu_read_ctl e%0d: got %b required %b", k, ctl, exp_ctl[k]);
      end
      if (k == 5) begin
        vectors++;
        if (rdata !== 8'hAA) begin
          miscompares++;
          $display("FAIL cpu_read_rdata: got %h required aa", rdata);
        end
        cpu_req = 0;
      end
    end
  endtask

  task automatic test_dma_write;
    logic [8:0] exp_ctl [8];
    exp_ctl = '{9'b1_0_1_1_0_1_0_0_1, 9'b1_0_1_0_0_1_0_0_1, 9'b1_0_1_0_0_1_0_0_1,
                9'b1_0_1_0_0_1_0_0_1, 9'b1_0_1_1_0_1_0_0_1, 9'b1_1_1_1_1_0_0_1_1,
                9'b1_1_1_1_1_0_0_0_1, 9'b1_1_1_1_1_0_0_0_0};
    dma_req = 1; dma_rw = 0; dma_wdata = 8'h5C;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 0) begin
        dma_wdata = 8'h00;
        dma_rw = 1;
      end
      vectors++;
      if (ctl !== exp_ctl[k]) begin
        miscompares++;
        $display("FAIL dma_write_ctl e%0d: got %b required %b", k, ctl, exp_ctl[k]);
      end
      if (k == 1 || k == 4) begin
        vectors++;
        if (pd_out !== 8'h5C) begin
          miscompares++;
          $display("FAIL dma_write_pd_out e%0d: got %h required 5c", k, pd_out);
        end
      end
      if (k == 5) dma_req = 0;
    end
  endtask

  task automatic test_simultaneous;
    logic owners [3];
    logic exp_own [3];
    logic prev_css, prev_dack;
    int   ng;
`ifdef PPORT_FAIR_ARB_EN
    exp_own = '{1'b0, 1'b1, 1'b0};
`else
    exp_own = '{1'b0, 1'b0, 1'b0};
`endif
    owners = '{1'b1, 1'b1, 1'b1};
    prev_css = 1; prev_dack = 1; ng = 0;
    cpu_req = 1; dma_req = 1; cpu_rw = 1; dma_rw = 1; pd_in = 8'h77;
    for (int k = 0; k < 40 && ng < 3; k++) begin
      tick();
      if (!css_n && prev_css) begin owners[ng] = 1'b0; ng++; end
      else if (!dack_n && prev_dack) begin owners[ng] = 1'b1; ng++; end
      vectors++;
      if (!css_n && !dack_n) begin
        miscompares++;
        $display("FAIL sim_select_overlap: _CSS=%b _DACK=%b required not both 0", css_n, dack_n);
      end
      prev_css = css_n; prev_dack = dack_n;
    end
    cpu_req = 0; dma_req = 0;
    wait_idle();
    vectors++;
    if (ng !== 3) begin
      miscompares++;
      $display("FAIL sim_grant_count: got %0d required 3", ng);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (owners[i] !== exp_own[i]) begin
        miscompares++;
        $display("FAIL sim_owner_%0d: got %b required %b (0=CPU 1=DMA)", i, owners[i], exp_own[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   t_grant [2];
    int   ng, na;
    logic prev_dack;
    t_grant = '{0, 0};
    ng = 0; na = 0; prev_dack = 1;
    dma_req = 1; dma_rw = 1; pd_in = 8'h01;
    for (int k = 0; k < 40 && na < 2; k++) begin
      tick();
      if (!dack_n && prev_dack && ng < 2) begin
        t_grant[ng] = k;
        ng++;
        if (ng == 2) dma_req = 0;
      end
      if (dma_ack) begin
        vectors++;
        if (rdata !== ((na == 0) ? 8'h01 : 8'h02)) begin
          miscompares++;
          $display("FAIL b2b_rdata_%0d: got %h required %h", na, rdata, (na == 0) ? 8'h01 : 8'h02);
        end
        na++;
        pd_in = 8'h02;
      end
      vectors++;
      if ((!ior_n && !iow_n) || pd_oe) begin
        miscompares++;
        $display("FAIL b2b_strobe: _IOR=%b _IOW=%b pd_oe=%b required no overlap, pd_oe 0", ior_n, iow_n, pd_oe);
      end
      prev_dack = dack_n;
    end
    wait_idle();
    vectors++;
    if (ng !== 2 || na !== 2) begin
      miscompares++;
      $display("FAIL b2b_counts: grants=%0d acks=%0d required 2/2", ng, na);
    end
    vectors++;
    if (t_grant[1] - t_grant[0] !== 8) begin
      miscompares++;
      $display("FAIL b2b_spacing: got %0d required 8", t_grant[1] - t_grant[0]);
    end
  endtask

  task automatic test_reset_mid_strobe;
    int k;
    cpu_req = 1; cpu_rw = 0; cpu_wdata = 8'h3C;
    tick();
    tick();
    vectors++;
    if (iow_n !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_in_strobe: _IOW=%b required 0", iow_n);
    end
    #2 RST = 1'b1;
    #1;
    vectors++;
    if (ctl !== 9'b1_1_1_1_1_0_0_0_0) begin
      miscompares++;
      $display("FAIL rst_mid_async: got %b required %b", ctl, 9'b1_1_1_1_1_0_0_0_0);
    end
    repeat (2) begin
      tick();
      vectors++;
      if (ctl !== 9'b1_1_1_1_1_0_0_0_0) begin
        miscompares++;
        $display("FAIL rst_mid_held: got %b required %b", ctl, 9'b1_1_1_1_1_0_0_0_0);
      end
    end
    RST = 1'b0;
    tick();
    vectors++;
    if (ctl !== 9'b0_1_1_1_0_1_0_0_1 || pd_out !== 8'h3C) begin
      miscompares++;
      $display("FAIL rst_regrant: ctl=%b pd_out=%h required %b/3c", ctl, pd_out, 9'b0_1_1_1_0_1_0_0_1);
    end
    k = 0;
    while (!cpu_ack && k < 20) begin
      tick();
      k++;
    end
    vectors++;
    if (cpu_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_regrant_ack: cpu_ack=%b required 1 within 20 clocks", cpu_ack);
    end
    cpu_req = 0;
    wait_idle();
  endtask

  task automatic test_param_override;
    int   ack_at, iow_cnt, ng, k;
    int   g [2];
    logic prev_css;
    ack_at = -1; iow_cnt = 0; ng = 0; prev_css = 1;
    g = '{-1, -1};
    cpu_req2 = 1; cpu_rw2 = 0; cpu_wdata2 = 8'h11;
    for (int e = 0; e < 12; e++) begin
      tick();
      if (!css2_n && prev_css && ng < 2) begin g[ng] = e; ng++; end
      if (cpu_ack2 && ack_at < 0) ack_at = e;
      if (!iow2_n) iow_cnt++;
      prev_css = css2_n;
    end
    cpu_req2 = 0;
    k = 0;
    while (busy2 && k < 40) begin
      tick();
      k++;
    end
    vectors++;
    if (busy2 !== 1'b0) begin
      miscompares++;
      $display("FAIL param_idle: busy=%b required 0", busy2);
    end
    vectors++;
    if (iow_cnt !== 5) begin
      miscompares++;
      $display("FAIL param_strobe_width: got %0d required 5", iow_cnt);
    end
    vectors++;
    if (ack_at !== 9) begin
      miscompares++;
      $display("FAIL param_ack_edge: got e%0d required e9", ack_at);
    end
    vectors++;
    if (g[0] !== 0 || g[1] !== 11) begin
      miscompares++;
      $display("FAIL param_grants: got e%0d,e%0d required e0,e11", g[0], g[1]);
    end
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_strobe();
    test_param_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pport_arbiter
`default_nettype wire
